// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM state encoding and the default bit period.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    TX_START_BIT  = 3'd1,
    TX_DATA_BITS  = 3'd2,
    TX_STOP_BIT   = 3'd3,
    CLEAN_UP      = 3'd4,
    TX_PARITY_BIT = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..i_tc_val while enabled, pulses o_tc on the last count and
// wraps to 0 on its own. The receiver can reuse it with a half-period terminal value.
module uart_baud_cnt #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_tc_val,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_count;

  assign o_tc = i_en && (r_count == i_tc_val);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr || o_tc) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 1 start, 8 data bits LSB first, STOP_BITS stop bits, valid/ready input.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD) after data bit 7.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       uart_txd
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT * STOP_BITS);
  localparam logic [CNT_W-1:0] BIT_TC  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_TC = CNT_W'(CLKS_PER_BIT * STOP_BITS - 1);

  if (CLKS_PER_BIT < 2 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1)
  begin : g_bad_cfg
    $error("uart_tx: unsupported parameter combination");
  end

  uart_state_e      r_state, w_state_n;
  logic [7:0]       r_shift, w_shift_n;
  logic [2:0]       r_bit_idx, w_bit_idx_n;
  logic             r_txd, w_txd_n;
  logic             w_cnt_clr, w_cnt_en, w_cnt_tc;
  logic [CNT_W-1:0] w_tc_val;

  uart_baud_cnt #(.WIDTH(CNT_W)) u_baud_cnt (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_cnt_clr),
    .i_en     (w_cnt_en),
    .i_tc_val (w_tc_val),
    .o_tc     (w_cnt_tc)
  );

`ifdef UART_TX_PARITY_EN
  // Parity is captured with the byte, since the shift register is consumed as bits go out.
  logic r_parity;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if (r_state == IDLE && tx_valid) begin
      r_parity <= (^tx_data) ^ (PARITY_ODD != 0);
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_txd     <= 1'b1;
    end else begin
      r_state   <= w_state_n;
      r_shift   <= w_shift_n;
      r_bit_idx <= w_bit_idx_n;
      r_txd     <= w_txd_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_shift_n   = r_shift;
    w_bit_idx_n = r_bit_idx;
    w_txd_n     = r_txd;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    w_tc_val    = BIT_TC;
    case (r_state)
      IDLE: begin
        w_txd_n     = 1'b1;
        w_cnt_clr   = 1'b1;
        w_bit_idx_n = '0;
        if (tx_valid) begin
          w_shift_n = tx_data;
          w_txd_n   = 1'b0;
          w_state_n = TX_START_BIT;
        end
      end
      TX_START_BIT: begin
        w_cnt_en = 1'b1;
        if (w_cnt_tc) begin
          w_txd_n   = r_shift[0];
          w_state_n = TX_DATA_BITS;
        end
      end
      TX_DATA_BITS: begin
        w_cnt_en = 1'b1;
        if (w_cnt_tc) begin
          w_bit_idx_n = r_bit_idx + 3'd1;
          w_shift_n   = r_shift >> 1;
          w_txd_n     = r_shift[1];
          if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_txd_n   = r_parity;
            w_state_n = TX_PARITY_BIT;
`else
            w_txd_n   = 1'b1;
            w_state_n = TX_STOP_BIT;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY_BIT: begin
        w_cnt_en = 1'b1;
        if (w_cnt_tc) begin
          w_txd_n   = 1'b1;
          w_state_n = TX_STOP_BIT;
        end
      end
`endif
      TX_STOP_BIT: begin
        w_cnt_en = 1'b1;
        w_tc_val = STOP_TC;
        if (w_cnt_tc) begin
          w_state_n = CLEAN_UP;
        end
      end
      CLEAN_UP: begin
        w_txd_n   = 1'b1;
        w_state_n = IDLE;
      end
      default: begin
        w_txd_n   = 1'b1;
        w_state_n = IDLE;
      end
    endcase
  end

  assign tx_ready = (r_state == IDLE);
  assign tx_busy  = (r_state != IDLE);
  assign tx_done  = (r_state == CLEAN_UP);
  assign uart_txd = r_txd;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: accepted bytes are queued, a line-level receiver model
// reconstructs each frame from uart_txd and checks it against the queue head.
module tb_uart_tx;

  localparam int CPB  = 434;
  localparam int STOP = 1;
  localparam int PODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME = (9 + PAR + STOP) * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_busy, tx_done, uart_txd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_push = 0;
  int n_abort = 0;
  int frames_rx = 0;
  logic [7:0] exp_q[$];

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(STOP), .PARITY_ODD(PODD)) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .uart_txd (uart_txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_level(input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (PAR == 1 && slot == 9) return logic'(($countones(b) + PODD) % 2);
    return 1'b1;
  endfunction

  // Receiver model: one sample per cycle for the whole frame, then the done pulse.
  initial begin : monitor
    logic [7:0] exp_b, rx_b;
    int bad, slot;
    bit abort;
    forever begin
      @(negedge clk);
      if (reset || uart_txd) continue;
      chk("frame_expected", int'(exp_q.size() != 0), 1);
      exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
      rx_b  = 8'h00;
      bad   = 0;
      abort = 1'b0;
      for (int s = 0; s < FRAME; s++) begin
        if (s > 0) @(negedge clk);
        if (reset) begin
          abort = 1'b1;
          break;
        end
        slot = s / CPB;
        if (slot >= 1 && slot <= 8 && (s % CPB) == CPB / 2) rx_b[slot-1] = uart_txd;
        if (uart_txd !== exp_level(exp_b, slot) || tx_done || !tx_busy || tx_ready) bad++;
      end
      if (abort) begin
        n_abort++;
        continue;
      end
      chk("rx_byte", int'(rx_b), int'(exp_b));
      chk("line_shape", bad, 0);
      @(negedge clk);
      chk("done_at_frame_end", int'(tx_done), 1);
      chk("line_high_cleanup", int'(uart_txd), 1);
      frames_rx++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit keep_valid, output int acc_cyc);
    int n = 0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = b;
    while (!tx_ready && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    chk("accept", int'(tx_ready), 1);
    acc_cyc = cyc;
    if (tx_ready) begin
      exp_q.push_back(b);
      n_push++;
    end
    @(posedge clk);
    #1;
    if (!keep_valid) begin
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (!(frames_rx + n_abort == n_push && !tx_busy) && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    chk("drain", int'(frames_rx + n_abort == n_push && !tx_busy), 1);
  endtask

  initial begin : stim
    int acc, prev, bad, done_seen;
    logic [7:0] hello [6];
    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0A};

    #100;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_txd", int'(uart_txd), 1);
    chk("rst_ready", int'(tx_ready), 1);
    chk("rst_busy", int'(tx_busy), 0);
    bad = 0;
    done_seen = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx_done) done_seen++;
      if (!uart_txd || !tx_ready || tx_busy) bad++;
    end
    chk("idle_no_done", done_seen, 0);
    chk("idle_stable", bad, 0);

    send_byte(8'h41, 1'b0, acc);
    wait_drain();

    // Back-to-back with tx_valid held: frame, clean-up cycle, one idle cycle.
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      send_byte(hello[i], i < 5, acc);
      if (i > 0) chk("b2b_spacing", acc - prev, FRAME + 2);
      prev = acc;
    end
    wait_drain();
    chk("hello_frames", frames_rx, 7);

    // Pulse while busy must neither be accepted nor corrupt the frame in flight.
    send_byte(8'h3C, 1'b0, acc);
    repeat (2000) @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    chk("busy_not_ready", int'(tx_ready), 0);
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    wait_drain();
    repeat (FRAME / 4) @(negedge clk);
    chk("busy_pulse_dropped", frames_rx, 8);

    // Reset during data bit 3 (cycles 4*CPB..5*CPB-1 after acceptance).
    send_byte(8'hA5, 1'b0, acc);
    repeat (4 * CPB + CPB / 2 - 1) @(posedge clk);
    #2;
    chk("pre_rst_bit3", int'(uart_txd), 0);
    reset = 1'b1;
    #1;
    chk("async_rst_txd", int'(uart_txd), 1);
    chk("async_rst_ready", int'(tx_ready), 1);
    chk("async_rst_busy", int'(tx_busy), 0);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    chk("abort_count", n_abort, 1);
    send_byte(8'h55, 1'b0, acc);
    wait_drain();

`ifdef UART_TX_PARITY_EN
    send_byte(8'h07, 1'b0, acc);
    wait_drain();
`endif

    for (int i = 0; i < 4; i++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      send_byte(8'($urandom), gap == 0 && i < 3, acc);
      repeat (gap * 7) @(negedge clk);
    end
    wait_drain();
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
